// File: rtl/pc_pkg.sv
// Shared state encodings and PC arithmetic constants for the IF-stage next-PC controller.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] MAX_PC_DEFAULT  = 32'd52;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/pc_next_calc.sv
// Adder with out-of-range wrap to 0 and word-alignment check; purely combinational, zero latency,
// no flow control.
module pc_next_calc
    import pc_pkg::*;
#(
    parameter logic [31:0] MAX_PC = MAX_PC_DEFAULT
) (
    input  logic [31:0] i_base,
    input  logic [31:0] i_inc,
    output logic [31:0] o_next,
    output logic        o_misaligned
);

    logic [31:0] w_sum;

    // Carry out of bit 31 is dropped; anything past the top of program memory restarts at 0.
    assign w_sum        = i_base + i_inc;
    assign o_next       = (w_sum > MAX_PC) ? 32'd0 : w_sum;
    assign o_misaligned = |(w_sum & WORD_ALIGN_MASK);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC select and PC write enable for the IF stage: zero-latency outputs from state + inputs,
// hazard stalls hold the PC (WE low), redirects flush IF/ID, errors park the sequencer in HALT.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] MAX_PC       = MAX_PC_DEFAULT,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          MAX_STALL    = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc,
    input  logic        i_stall_req,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_halt,
    input  logic        i_resume,
    output logic [31:0] o_new_pc,
    output logic        o_write_enable,
    output logic        o_if_flush,
    output logic        o_halted,
    output logic        o_stall_timeout,
    output logic        o_fault
);

    pc_state_t   r_state;
    logic [3:0]  r_stall_cnt;
    logic [1:0]  r_flush_cnt;
    logic        r_stall_timeout;
    logic        r_fault;

    pc_state_t   w_state_nxt;
    logic [3:0]  w_stall_nxt;
    logic [1:0]  w_flush_nxt;
    logic        w_timeout_set;
    logic        w_fault_set;
    logic [31:0] w_new_pc;
    logic        w_we;
    logic        w_if_flush;

    logic [31:0] w_seq_pc;
    logic        w_seq_mis;
    logic [31:0] w_sel_target;
    logic [31:0] w_tgt_pc;
    logic        w_tgt_mis;
    logic        w_redirect;

    assign w_sel_target = i_branch_taken ? i_branch_target : i_jump_target;
    assign w_redirect   = i_branch_taken | i_jump;

    pc_next_calc #(.MAX_PC(MAX_PC)) u_seq_calc (
        .i_base       (i_pc),
        .i_inc        (PC_STEP),
        .o_next       (w_seq_pc),
        .o_misaligned (w_seq_mis)
    );

    pc_next_calc #(.MAX_PC(MAX_PC)) u_tgt_calc (
        .i_base       (w_sel_target),
        .i_inc        (32'd0),
        .o_next       (w_tgt_pc),
        .o_misaligned (w_tgt_mis)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_RUN;
            r_stall_cnt     <= '0;
            r_flush_cnt     <= '0;
            r_stall_timeout <= 1'b0;
            r_fault         <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_stall_cnt     <= w_stall_nxt;
            r_flush_cnt     <= w_flush_nxt;
            r_stall_timeout <= r_stall_timeout | w_timeout_set;
            r_fault         <= r_fault | w_fault_set;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_stall_nxt   = '0;
        w_flush_nxt   = r_flush_cnt;
        w_timeout_set = 1'b0;
        w_fault_set   = 1'b0;
        w_new_pc      = i_pc;
        w_we          = 1'b0;
        w_if_flush    = 1'b0;

        case (r_state)
            ST_RUN, ST_FLUSH: begin
                w_if_flush = (r_state == ST_FLUSH);
                if (i_halt) begin
                    w_state_nxt = ST_HALT;
                end else if ((r_state == ST_RUN) && w_redirect) begin
                    if (w_tgt_mis) begin
                        w_fault_set = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_new_pc    = w_tgt_pc;
                        w_we        = 1'b1;
                        w_if_flush  = 1'b1;
                        w_flush_nxt = 2'(FLUSH_CYCLES - 1);
                        w_state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                    end
                end else if (i_stall_req) begin
                    w_stall_nxt = r_stall_cnt + 4'd1;
                    if (r_stall_cnt == 4'(MAX_STALL - 1)) begin
                        w_timeout_set = 1'b1;
                        w_state_nxt   = ST_HALT;
                    end
                end else if (w_seq_mis) begin
                    // A misaligned current PC can never step onto a legal fetch address.
                    w_fault_set = 1'b1;
                    w_state_nxt = ST_HALT;
                end else begin
                    w_new_pc = w_seq_pc;
                    w_we     = 1'b1;
                    if (r_state == ST_FLUSH) begin
                        if (r_flush_cnt <= 2'd1) begin
                            w_flush_nxt = '0;
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_flush_nxt = r_flush_cnt - 2'd1;
                        end
                    end
                end
            end
            ST_HALT: begin
                if (i_resume && !i_halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Reset forces the PC-register controls inactive immediately, not at the next edge.
    assign o_new_pc        = i_rst_n ? w_new_pc : 32'd0;
    assign o_write_enable  = i_rst_n & w_we;
    assign o_if_flush      = i_rst_n & w_if_flush;
    assign o_halted        = i_rst_n & (r_state == ST_HALT);
    assign o_stall_timeout = r_stall_timeout;
    assign o_fault         = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a two-cycle flush window; inputs change on the falling
// edge and outputs are sampled 1ns later, well before the next rising edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall_req;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;
    logic [31:0] new_pc;
    logic        write_enable;
    logic        if_flush;
    logic        halted;
    logic        stall_timeout;
    logic        fault;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .MAX_PC       (32'd52),
        .FLUSH_CYCLES (2),
        .MAX_STALL    (15)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_pc            (pc),
        .i_stall_req     (stall_req),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_halt          (halt),
        .i_resume        (resume),
        .o_new_pc        (new_pc),
        .o_write_enable  (write_enable),
        .o_if_flush      (if_flush),
        .o_halted        (halted),
        .o_stall_timeout (stall_timeout),
        .o_fault         (fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic st, input logic br,
                         input logic [31:0] bt, input logic j, input logic [31:0] jt,
                         input logic h, input logic r);
        pc            = p;
        stall_req     = st;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        halt          = h;
        resume        = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ctl(input string tag, input logic [31:0] npc, input logic we,
                           input logic fl, input logic hl);
        chk({tag, ".npc"}, new_pc, npc);
        chk({tag, ".we"},  {31'd0, write_enable}, {31'd0, we});
        chk({tag, ".fl"},  {31'd0, if_flush}, {31'd0, fl});
        chk({tag, ".hlt"}, {31'd0, halted}, {31'd0, hl});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h20, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_ctl("rst", 32'h0, 0, 0, 0);
        chk("rst.to", {31'd0, stall_timeout}, 32'd0);
        chk("rst.flt", {31'd0, fault}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_ctl("rel", 32'h24, 1, 0, 0);
        tick();

        drive(32'h30, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("seq30", 32'h34, 1, 0, 0);
        tick();
        drive(32'h34, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("wrap34", 32'h0, 1, 0, 0);
        tick();

        // Branch beats jump; a branch arriving in the flush window is ignored.
        drive(32'h10, 0, 1, 32'h28, 1, 32'h08, 0, 0);
        chk_ctl("redir", 32'h28, 1, 1, 0);
        tick();
        drive(32'h28, 0, 1, 32'h04, 0, 0, 0, 0);
        chk_ctl("flushbr", 32'h2C, 1, 1, 0);
        tick();
        drive(32'h2C, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("postfl", 32'h30, 1, 0, 0);
        tick();

        for (int i = 0; i < 3; i++) begin
            drive(32'h0C, 1, 0, 0, 0, 0, 0, 0);
            chk_ctl($sformatf("stall%0d", i), 32'h0C, 0, 0, 0);
            tick();
        end
        drive(32'h0C, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("unstall", 32'h10, 1, 0, 0);
        tick();

        for (int i = 0; i < 15; i++) begin
            drive(32'h0C, 1, 0, 0, 0, 0, 0, 0);
            chk($sformatf("pre_to%0d", i), {31'd0, stall_timeout}, 32'd0);
            tick();
        end
        chk("to.set", {31'd0, stall_timeout}, 32'd1);
        chk_ctl("to.halt", 32'h0C, 0, 0, 1);

        drive(32'h0C, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(32'h0C, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("resume", 32'h10, 1, 0, 0);
        chk("to.sticky", {31'd0, stall_timeout}, 32'd1);

        // Halt outranks a taken branch; Halt with Resume keeps the sequencer parked.
        drive(32'h10, 0, 1, 32'h20, 0, 0, 1, 0);
        chk_ctl("haltbr", 32'h10, 0, 0, 0);
        tick();
        drive(32'h10, 0, 0, 0, 0, 0, 1, 1);
        tick();
        chk_ctl("haltres", 32'h10, 0, 0, 1);
        drive(32'h10, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(32'h10, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("run2", 32'h14, 1, 0, 0);

        drive(32'h10, 0, 0, 0, 1, 32'h06, 0, 0);
        chk_ctl("misjmp", 32'h10, 0, 0, 0);
        tick();
        drive(32'h10, 0, 0, 0, 0, 0, 0, 0);
        chk("flt.set", {31'd0, fault}, 32'd1);
        chk_ctl("flt.halt", 32'h10, 0, 0, 1);
        drive(32'h10, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(32'h10, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("flt.res", 32'h14, 1, 0, 0);
        chk("flt.sticky", {31'd0, fault}, 32'd1);

        drive(32'h10, 0, 0, 0, 1, 32'h40, 0, 0);
        chk_ctl("tgtwrap", 32'h0, 1, 1, 0);
        tick();
        drive(32'h00, 1, 0, 0, 0, 0, 0, 0);
        chk_ctl("flstall", 32'h0, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        chk_ctl("rstfl", 32'h0, 0, 0, 0);
        chk("rstfl.to", {31'd0, stall_timeout}, 32'd0);
        chk("rstfl.flt", {31'd0, fault}, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(32'h00, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("relfl", 32'h04, 1, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
